load_store_unit: RTL and testbench
==================================

# load_store_unit

Request-side front end for the synchronous word memory: accepts one byte/halfword/word load or store at a time from the core over a valid/ready handshake, and drives the memory's single-cycle read/write strobes. Sub-word stores use read-modify-write because the memory has no byte enables. Loads are sign- or zero-extended. Misaligned or illegal-size requests return an error response and never touch memory.

## Interface
Parameters:
- ADDR_WIDTH, 32: byte-address width on the core side; the memory side gets ADDR_WIDTH-2 word-address bits.
- WORD_WIDTH, 32: data width; only 32 is supported.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  ADDR_WIDTH  byte address, little-endian.
- req_wdata  in  WORD_WIDTH  store data, right-aligned (low bits).
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  WORD_WIDTH  extended load data; 0 for stores and errors.
- rsp_err  out  1  valid with rsp_valid; misaligned or illegal size.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_addr  out  ADDR_WIDTH-2  word address, req_addr[ADDR_WIDTH-1:2].
- mem_wdata  out  WORD_WIDTH  full word to write.
- mem_rdata  in  WORD_WIDTH  memory read data; valid only in the cycle after a mem_read cycle.

## Operation
- **Accept:** a request is accepted when req_valid && req_ready. On that edge, latch we, size, unsigned, addr and wdata. Only one request is outstanding at a time.
- **Error check at accept:** the request is an error if size=11, if half with addr[0]=1, or if word with addr[1:0]≠00.
- **FSM states:** IDLE, RD, CAP, WR, RESP. Transitions out of IDLE on accept:
  - error → RESP
  - load → RD
  - word store → WR
  - byte/half store → RD
- **RD:** mem_read=1 → CAP.
- **CAP:** sample mem_rdata.
  - Load: select the lane (byte at addr[1:0]*8, half at addr[1]*16), extend, register into the result → RESP.
  - Sub-word store: merge req_wdata's low byte/half into that lane of mem_rdata, register into mem_wdata → WR.
- **WR:** mem_write=1, with mem_wdata either the latched word or the merged word → RESP.
- **RESP:** rsp_valid=1, with rsp_err and rsp_rdata held → IDLE.
- **Memory strobes:**
  - mem_read and mem_write are never high in the same cycle.
  - Both are 0 in IDLE, CAP and RESP.
  - mem_addr and mem_wdata are stable in every state after accept.
- **Reset:**
  - While rst_n=0, the state goes to IDLE and all outputs are 0, including req_ready.
  - Reset mid-operation abandons the request: no response is issued, and no write is issued if reset arrives before WR.
  - A write strobe already in WR completes only in the cycle it is driven.

## Timing
Let A be the accept edge; cycle A+n is n cycles after A.
- **Load:** RD at A+1, CAP at A+2, rsp_valid at A+3.
- **Word store:** mem_write at A+1, rsp_valid at A+2.
- **Sub-word store:** mem_read at A+1, merge at A+2, mem_write at A+3, rsp_valid at A+4.
- **Error:** rsp_valid with rsp_err=1 at A+1; no strobes.
- **Back-to-back requests:** req_ready rises the cycle after RESP. Peak rate is one word store per 3 cycles.
- **Response channel:** there is no response backpressure; the core must sample rsp_* in the pulse cycle.
- **Outputs:** all outputs are registered.

## Test plan
- **Reset:** hold rst_n=0 for 3 cycles with req_valid=1 → req_ready=0, rsp_valid=0, mem_read=0, mem_write=0 throughout. After release, req_ready=1 on the first cycle.
- **Word store then word load:** store 0xDEADBEEF to 0x10 → mem_write at A+1 with mem_addr=0x4 and mem_wdata=0xDEADBEEF; rsp_valid at A+2 with rsp_rdata=0. Load word 0x10 → rsp_rdata=0xDEADBEEF at A+3.
- **Byte RMW:** with word 0x11223344 at 0x10, store byte 0x1A5 to 0x13 → mem_read at A+1, mem_write at A+3 with 0xA5223344. A signed byte load from 0x13 → 0xFFFFFFA5; an unsigned one → 0x000000A5.
- **Halfword load extension:** with 0xA5223344 at 0x10, signed half load at 0x12 → 0xFFFFA522. Unsigned half load at 0x10 → 0x00003344.
- **Errors:** half at 0x11, word at 0x12, and size=11 each give rsp_valid and rsp_err at A+1. mem_read and mem_write stay 0, and memory contents are unchanged.
- **Reset mid-RMW:** drop rst_n during CAP of a byte store → no mem_write pulse and no rsp_valid. The memory word is unchanged. req_ready=1 on the first cycle after rst_n returns high.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Core request/response and word-memory bus bundle for the load/store unit.
// slave is the unit's view; master is the core plus memory side.
interface load_store_unit_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int WORD_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [WORD_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [WORD_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_WIDTH-3:0] mem_addr;
  logic [WORD_WIDTH-1:0] mem_wdata;
  logic [WORD_WIDTH-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store front end for a byte-enable-free word memory: sub-word stores
// are read-modify-write, loads are lane-selected and sign/zero extended.
//
// state | meaning
// IDLE  | req_ready high, waiting for a request
// RD    | mem_read strobe for a load or the read half of an RMW
// CAP   | mem_rdata valid: extend into result or merge into write word
// WR    | mem_write strobe
// RESP  | one-cycle rsp_valid pulse
module load_store_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int WORD_WIDTH = 32
) (
  input logic               clk,
  input logic               rst_n,
  load_store_unit_if.slave  bus
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RD   = 3'd1;
  localparam logic [2:0] CAP  = 3'd2;
  localparam logic [2:0] WR   = 3'd3;
  localparam logic [2:0] RESP = 3'd4;

  logic [2:0]            state, state_d;
  logic                  we_q, uns_q;
  logic [1:0]            size_q, off_q;
  logic [15:0]           wdata_q;
  logic                  accept, req_err;
  logic [7:0]            rd_byte;
  logic [15:0]           rd_half;
  logic [WORD_WIDTH-1:0] load_ext, merged;

  always_comb begin
    accept  = bus.req_valid && bus.req_ready;
    req_err = (bus.req_size == 2'b11) ||
              (bus.req_size == 2'b01 && bus.req_addr[0]) ||
              (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00);
    state_d = state;
    case (state)
      IDLE: if (accept) begin
        if (req_err)                                state_d = RESP;
        else if (bus.req_we && bus.req_size == 2'b10) state_d = WR;
        else                                        state_d = RD;
      end
      RD:      state_d = CAP;
      CAP:     state_d = we_q ? WR : RESP;
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    case (off_q)
      2'd0:    rd_byte = bus.mem_rdata[7:0];
      2'd1:    rd_byte = bus.mem_rdata[15:8];
      2'd2:    rd_byte = bus.mem_rdata[23:16];
      default: rd_byte = bus.mem_rdata[31:24];
    endcase
    rd_half = off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

    case (size_q)
      2'b00:   load_ext = uns_q ? {{(WORD_WIDTH-8){1'b0}}, rd_byte}
                                : {{(WORD_WIDTH-8){rd_byte[7]}}, rd_byte};
      2'b01:   load_ext = uns_q ? {{(WORD_WIDTH-16){1'b0}}, rd_half}
                                : {{(WORD_WIDTH-16){rd_half[15]}}, rd_half};
      default: load_ext = bus.mem_rdata;
    endcase

    merged = bus.mem_rdata;
    if (size_q == 2'b00) begin
      case (off_q)
        2'd0:    merged[7:0]   = wdata_q[7:0];
        2'd1:    merged[15:8]  = wdata_q[7:0];
        2'd2:    merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end else if (off_q[1]) begin
      merged[31:16] = wdata_q;
    end else begin
      merged[15:0] = wdata_q;
    end
  end

  // Strobes and ready are registered off the next state so every output is a flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      we_q          <= 1'b0;
      uns_q         <= 1'b0;
      size_q        <= 2'b00;
      off_q         <= 2'b00;
      wdata_q       <= '0;
      bus.req_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
      bus.mem_read  <= 1'b0;
      bus.mem_write <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      state         <= state_d;
      bus.req_ready <= (state_d == IDLE);
      bus.mem_read  <= (state_d == RD);
      bus.mem_write <= (state_d == WR);
      bus.rsp_valid <= (state_d == RESP);
      if (accept) begin
        we_q          <= bus.req_we;
        uns_q         <= bus.req_unsigned;
        size_q        <= bus.req_size;
        off_q         <= bus.req_addr[1:0];
        wdata_q       <= bus.req_wdata[15:0];
        bus.mem_addr  <= bus.req_addr[ADDR_WIDTH-1:2];
        bus.mem_wdata <= (bus.req_we && bus.req_size == 2'b10) ? bus.req_wdata : '0;
        bus.rsp_rdata <= '0;
        bus.rsp_err   <= req_err;
      end
      if (state == CAP) begin
        if (we_q) bus.mem_wdata <= merged;
        else      bus.rsp_rdata <= load_ext;
      end
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench: table of requests against a small word memory, plus reset sequences.
module tb_load_store_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  load_store_unit_if #(.ADDR_WIDTH(32), .WORD_WIDTH(32)) bus ();

  load_store_unit #(.ADDR_WIDTH(32), .WORD_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  logic [31:0] mem [16];
  always @(posedge clk) begin
    if (bus.mem_write) mem[bus.mem_addr[3:0]] <= bus.mem_wdata;
    if (bus.mem_read)  bus.mem_rdata <= mem[bus.mem_addr[3:0]];
  end

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          rd_cyc;
    int          wr_cyc;
    logic [31:0] wr_data;
    int          lat;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];

  function automatic vec_t mk(logic we, logic [1:0] size, logic uns, logic [31:0] addr,
                              logic [31:0] wdata, int rd_cyc, int wr_cyc, logic [31:0] wr_data,
                              int lat, logic err, logic [31:0] rdata);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.rd_cyc = rd_cyc; v.wr_cyc = wr_cyc; v.wr_data = wr_data;
    v.lat = lat; v.err = err; v.rdata = rdata;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata);
    int n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_before_accept", {31'b0, bus.req_ready}, 32'd1);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int          rd_at = 0;
    int          wr_at = 0;
    int          got_lat = 0;
    logic [31:0] wdat = '0;
    string       tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    drive_req(v.we, v.size, v.uns, v.addr, v.wdata);
    for (int c = 1; c <= 8 && got_lat == 0; c++) begin
      @(negedge clk);
      if (bus.mem_read && rd_at == 0) rd_at = c;
      if (bus.mem_write && wr_at == 0) begin
        wr_at = c;
        wdat  = bus.mem_wdata;
      end
      if (bus.mem_read || bus.mem_write)
        check({tag, "_mem_addr"}, {2'b00, bus.mem_addr}, v.addr >> 2);
      if (bus.mem_read && bus.mem_write)
        check({tag, "_strobe_overlap"}, 32'd1, 32'd0);
      if (bus.rsp_valid) begin
        got_lat = c;
        check({tag, "_rsp_err"}, {31'b0, bus.rsp_err}, {31'b0, v.err});
        check({tag, "_rsp_rdata"}, bus.rsp_rdata, v.rdata);
      end
    end
    check({tag, "_latency"}, got_lat, v.lat);
    check({tag, "_read_cycle"}, rd_at, v.rd_cyc);
    check({tag, "_write_cycle"}, wr_at, v.wr_cyc);
    if (v.wr_cyc != 0) check({tag, "_write_data"}, wdat, v.wr_data);
    @(negedge clk);
    check({tag, "_ready_after_resp"}, {31'b0, bus.req_ready}, 32'd1);
  endtask

  initial begin
    //             we    size   uns   addr   wdata          rd wr wr_data        lat err  rdata
    vecs[0]  = mk(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 0, 1, 32'hDEADBEEF, 2, 1'b0, 32'h0);
    vecs[1]  = mk(1'b0, 2'b10, 1'b0, 32'h10, 32'h0,       1, 0, 32'h0,        3, 1'b0, 32'hDEADBEEF);
    vecs[2]  = mk(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 0, 1, 32'h11223344, 2, 1'b0, 32'h0);
    vecs[3]  = mk(1'b1, 2'b00, 1'b0, 32'h13, 32'h000001A5, 1, 3, 32'hA5223344, 4, 1'b0, 32'h0);
    vecs[4]  = mk(1'b0, 2'b00, 1'b0, 32'h13, 32'h0,       1, 0, 32'h0,        3, 1'b0, 32'hFFFFFFA5);
    vecs[5]  = mk(1'b0, 2'b00, 1'b1, 32'h13, 32'h0,       1, 0, 32'h0,        3, 1'b0, 32'h000000A5);
    vecs[6]  = mk(1'b0, 2'b01, 1'b0, 32'h12, 32'h0,       1, 0, 32'h0,        3, 1'b0, 32'hFFFFA522);
    vecs[7]  = mk(1'b0, 2'b01, 1'b1, 32'h10, 32'h0,       1, 0, 32'h0,        3, 1'b0, 32'h00003344);
    vecs[8]  = mk(1'b0, 2'b00, 1'b0, 32'h10, 32'h0,       1, 0, 32'h0,        3, 1'b0, 32'h00000044);
    vecs[9]  = mk(1'b0, 2'b00, 1'b0, 32'h12, 32'h0,       1, 0, 32'h0,        3, 1'b0, 32'h00000022);
    vecs[10] = mk(1'b1, 2'b01, 1'b0, 32'h10, 32'h12348001, 1, 3, 32'hA5228001, 4, 1'b0, 32'h0);
    vecs[11] = mk(1'b0, 2'b01, 1'b0, 32'h10, 32'h0,       1, 0, 32'h0,        3, 1'b0, 32'hFFFF8001);
    vecs[12] = mk(1'b0, 2'b01, 1'b1, 32'h11, 32'h0,       0, 0, 32'h0,        1, 1'b1, 32'h0);
    vecs[13] = mk(1'b1, 2'b10, 1'b0, 32'h12, 32'hCAFEF00D, 0, 0, 32'h0,        1, 1'b1, 32'h0);
    vecs[14] = mk(1'b0, 2'b11, 1'b0, 32'h10, 32'h0,       0, 0, 32'h0,        1, 1'b1, 32'h0);
    vecs[15] = mk(1'b1, 2'b11, 1'b0, 32'h10, 32'h55555555, 0, 0, 32'h0,        1, 1'b1, 32'h0);
    vecs[16] = mk(1'b0, 2'b10, 1'b0, 32'h10, 32'h0,       1, 0, 32'h0,        3, 1'b0, 32'hA5228001);
    vecs[17] = mk(1'b1, 2'b10, 1'b0, 32'h14, 32'h80000000, 0, 1, 32'h80000000, 2, 1'b0, 32'h0);
    vecs[18] = mk(1'b1, 2'b00, 1'b0, 32'h15, 32'hFFFFFF7F, 1, 3, 32'h80007F00, 4, 1'b0, 32'h0);
    vecs[19] = mk(1'b0, 2'b00, 1'b0, 32'h15, 32'h0,       1, 0, 32'h0,        3, 1'b0, 32'h0000007F);
    vecs[20] = mk(1'b0, 2'b10, 1'b0, 32'h14, 32'h0,       1, 0, 32'h0,        3, 1'b0, 32'h80007F00);
    vecs[21] = mk(1'b0, 2'b01, 1'b0, 32'h16, 32'h0,       1, 0, 32'h0,        3, 1'b0, 32'hFFFF8000);
    vecs[22] = mk(1'b1, 2'b10, 1'b0, 32'h11, 32'h01020304, 0, 0, 32'h0,        1, 1'b1, 32'h0);
    vecs[23] = mk(1'b0, 2'b10, 1'b1, 32'h10, 32'h0,       1, 0, 32'h0,        3, 1'b0, 32'hA5228001);

    bus.req_valid    = 1'b1;
    bus.req_we       = 1'b1;
    bus.req_size     = 2'b10;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h10;
    bus.req_wdata    = 32'h0;

    // Reset held with a request pending: nothing may move.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_req_ready", {31'b0, bus.req_ready}, 32'd0);
      check("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
      check("rst_mem_read",  {31'b0, bus.mem_read},  32'd0);
      check("rst_mem_write", {31'b0, bus.mem_write}, 32'd0);
    end
    rst_n = 1'b1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("rst_release_ready", {31'b0, bus.req_ready}, 32'd1);

    for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

    // Reset during CAP of a byte store must abandon it.
    @(negedge clk);
    drive_req(1'b1, 2'b00, 1'b0, 32'h13, 32'h00000077);
    @(negedge clk);
    check("rmw_rst_read_strobe", {31'b0, bus.mem_read}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rmw_rst_no_write", {31'b0, bus.mem_write}, 32'd0);
      check("rmw_rst_no_rsp",   {31'b0, bus.rsp_valid}, 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("rmw_rst_ready", {31'b0, bus.req_ready}, 32'd1);
    check("rmw_rst_mem_word", mem[4], 32'hA5228001);
    run_vec(mk(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1, 0, 32'h0, 3, 1'b0, 32'hA5228001), 99);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
